// File: rtl/ysyx_23060077_booth_wallace_pkg.sv
// Shared widths, stage bundles and helpers for the Booth/Wallace reducer.
// LEN-bit operands give 2*LEN-bit partial products, PP_N of them.
package ysyx_23060077_booth_wallace_pkg;

  localparam int LEN        = 34;
  localparam int PP_W       = 2 * LEN;
  localparam int PP_N       = 17;
  localparam int TAG_W      = 5;
  localparam int DATA_WIDTH = 32;
  localparam int S1_ROWS    = 6;
  localparam int S2_ROWS    = 2;

  typedef enum logic [1:0] {
    MUL_LO  = 2'd0,
    MUL_H   = 2'd1,
    MUL_HSU = 2'd2,
    MUL_HU  = 2'd3
  } mul_op_e;

  typedef logic [PP_W-1:0] row_t;

  typedef struct packed {
    logic                      hi;
    logic [TAG_W-1:0]          tag;
    row_t [S1_ROWS-1:0]        row;
  } s1_t;

  typedef struct packed {
    logic                      hi;
    logic [TAG_W-1:0]          tag;
    row_t [S2_ROWS-1:0]        row;
  } s2_t;

  function automatic logic [DATA_WIDTH-1:0] word_sel(
    input logic                    hi,
    input logic [2*DATA_WIDTH-1:0] p
  );
    return hi ? p[2*DATA_WIDTH-1:DATA_WIDTH]
              : p[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/ysyx_23060077_booth_wallace_if.sv
// Handshake bundle: partial products in (valid/ready), product word out.
// master = producer/consumer side, slave = reducer.
interface ysyx_23060077_booth_wallace_if;
  import ysyx_23060077_booth_wallace_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_hi;
  logic [TAG_W-1:0]      in_tag;
  row_t [PP_N-1:0]       pp;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic [TAG_W-1:0]      out_tag;

  modport master (
    output in_valid, in_hi, in_tag, pp, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_hi, in_tag, pp, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/ysyx_23060077_csa.sv
// W-bit 3:2 carry-save compressor.
// Ports: a/b/c in, sum = a^b^c, carry = maj(a,b,c) << 1 (modulo 2^W).
module ysyx_23060077_csa #(
  parameter int W = 68
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/ysyx_23060077_booth_wallace.sv
// 3-stage Wallace/CPA reducer: 17 Booth rows -> 64b product -> hi/lo word.
// Ports: clk, rst_n, flush, io (slave: pp/in handshake, result/out handshake).
module ysyx_23060077_booth_wallace
  import ysyx_23060077_booth_wallace_pkg::*;
(
  input logic                        clk,
  input logic                        rst_n,
  input logic                        flush,
  ysyx_23060077_booth_wallace_if.slave io
);

  row_t l1 [12];
  row_t l2 [8];
  row_t l3 [S1_ROWS];
  row_t l4 [4];
  row_t l5 [3];
  row_t l6 [S2_ROWS];

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s3_valid_q, s3_valid_d;
  logic [DATA_WIDTH-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0]      out_tag_q, out_tag_d;

  logic s1_load, s2_load, s3_load;
  row_t sum_full;
  logic [2*DATA_WIDTH-1:0] prod;
  logic unused_hi;

  // S1: 17 -> 12 -> 8 -> 6
  for (genvar g = 0; g < 5; g++) begin : g_l1
    ysyx_23060077_csa #(.W(PP_W)) u_csa (
      .a    (io.pp[3*g]),
      .b    (io.pp[3*g+1]),
      .c    (io.pp[3*g+2]),
      .sum  (l1[2*g]),
      .carry(l1[2*g+1])
    );
  end
  assign l1[10] = io.pp[15];
  assign l1[11] = io.pp[16];

  for (genvar g = 0; g < 4; g++) begin : g_l2
    ysyx_23060077_csa #(.W(PP_W)) u_csa (
      .a    (l1[3*g]),
      .b    (l1[3*g+1]),
      .c    (l1[3*g+2]),
      .sum  (l2[2*g]),
      .carry(l2[2*g+1])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_l3
    ysyx_23060077_csa #(.W(PP_W)) u_csa (
      .a    (l2[3*g]),
      .b    (l2[3*g+1]),
      .c    (l2[3*g+2]),
      .sum  (l3[2*g]),
      .carry(l3[2*g+1])
    );
  end
  assign l3[4] = l2[6];
  assign l3[5] = l2[7];

  // S2: 6 -> 4 -> 3 -> 2
  for (genvar g = 0; g < 2; g++) begin : g_l4
    ysyx_23060077_csa #(.W(PP_W)) u_csa (
      .a    (s1_q.row[3*g]),
      .b    (s1_q.row[3*g+1]),
      .c    (s1_q.row[3*g+2]),
      .sum  (l4[2*g]),
      .carry(l4[2*g+1])
    );
  end

  ysyx_23060077_csa #(.W(PP_W)) u_csa_l5 (
    .a    (l4[0]),
    .b    (l4[1]),
    .c    (l4[2]),
    .sum  (l5[0]),
    .carry(l5[1])
  );
  assign l5[2] = l4[3];

  ysyx_23060077_csa #(.W(PP_W)) u_csa_l6 (
    .a    (l5[0]),
    .b    (l5[1]),
    .c    (l5[2]),
    .sum  (l6[0]),
    .carry(l6[1])
  );

  // S3: product is modulo 2^64; the top row bits are dropped.
  assign sum_full  = s2_q.row[0] + s2_q.row[1];
  assign prod      = sum_full[2*DATA_WIDTH-1:0];
  assign unused_hi = ^sum_full[PP_W-1:2*DATA_WIDTH];

  always_comb begin
    s3_load = ~s3_valid_q | io.out_ready;
    s2_load = ~s2_valid_q | s3_load;
    s1_load = ~s1_valid_q | s2_load;

    s1_valid_d = ~flush & (s1_load ? io.in_valid : s1_valid_q);
    s2_valid_d = ~flush & (s2_load ? s1_valid_q : s2_valid_q);
    s3_valid_d = ~flush & (s3_load ? s2_valid_q : s3_valid_q);

    s1_d = s1_q;
    if (s1_load & io.in_valid) begin
      s1_d.hi  = io.in_hi;
      s1_d.tag = io.in_tag;
      for (int i = 0; i < S1_ROWS; i++) s1_d.row[i] = l3[i];
    end

    s2_d = s2_q;
    if (s2_load & s1_valid_q) begin
      s2_d.hi  = s1_q.hi;
      s2_d.tag = s1_q.tag;
      for (int i = 0; i < S2_ROWS; i++) s2_d.row[i] = l6[i];
    end

    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    if (s3_load & s2_valid_q) begin
      out_result_d = word_sel(s2_q.hi, prod);
      out_tag_d    = s2_q.tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s3_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_q         <= '0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s3_valid_q   <= s3_valid_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign io.in_ready   = s1_load;
  assign io.out_valid  = s3_valid_q;
  assign io.out_result = out_result_q;
  assign io.out_tag    = out_tag_q;

endmodule

// File: tb/tb_ysyx_23060077_booth_wallace.sv
// Directed + random bench for the Booth/Wallace reducer.
// Radix-4 Booth rows are generated here from the operands.
module tb_ysyx_23060077_booth_wallace;
  import ysyx_23060077_booth_wallace_pkg::*;

  typedef row_t [PP_N-1:0] pp_arr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks;
  int   fails;

  ysyx_23060077_booth_wallace_if bus ();

  ysyx_23060077_booth_wallace dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .io   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no end, required end");
    $fatal(1, "watchdog");
  end

  function automatic pp_arr_t gen_pp(
    input logic [31:0] a, input logic [31:0] b,
    input logic as, input logic bs
  );
    pp_arr_t r;
    logic [33:0] a34, b34;
    row_t ax, m;
    logic bm1;
    a34 = {{2{as & a[31]}}, a};
    b34 = {{2{bs & b[31]}}, b};
    ax  = {{34{a34[33]}}, a34};
    for (int i = 0; i < PP_N; i++) begin
      bm1 = (i == 0) ? 1'b0 : b34[2*i-1];
      case ({b34[2*i+1], b34[2*i], bm1})
        3'b001, 3'b010: m = ax;
        3'b011:         m = ax << 1;
        3'b100:         m = -(ax << 1);
        3'b101, 3'b110: m = -ax;
        default:        m = '0;
      endcase
      r[i] = m << (2 * i);
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_word(
    input logic [31:0] a, input logic [31:0] b,
    input logic as, input logic bs, input logic hi
  );
    logic [63:0] ea, eb, p;
    ea = {{32{as & a[31]}}, a};
    eb = {{32{bs & b[31]}}, b};
    p  = ea * eb;
    return hi ? p[63:32] : p[31:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_op(
    input logic [31:0] a, input logic [31:0] b,
    input logic as, input logic bs, input logic hi,
    input logic [4:0] tag
  );
    bus.pp     = gen_pp(a, b, as, bs);
    bus.in_hi  = hi;
    bus.in_tag = tag;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid: got %b exp 0", bus.out_valid);
    end
    checks++;
    if (bus.out_result !== 32'h0) begin
      fails++;
      $display("FAIL rst_result: got %h exp 0", bus.out_result);
    end
    checks++;
    if (bus.out_tag !== 5'h0) begin
      fails++;
      $display("FAIL rst_tag: got %h exp 0", bus.out_tag);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_in_ready: got %b exp 1", bus.in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_mul_vectors();
    logic [31:0] ta [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] tb [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic ts_a [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic ts_b [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic th [6]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] te [6] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE,
                            32'h00000001, 32'h80000000, 32'h80000000};
    logic [4:0] tag;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tag = 5'(i + 1);
      drive_op(ta[i], tb[i], ts_a[i], ts_b[i], th[i], tag);
      bus.in_valid = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL vec%0d_in_ready: got %b exp 1", i, bus.in_ready);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      #1;
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          fails++;
          $display("FAIL vec%0d_early%0d: got %b exp 0",
                   i, j, bus.out_valid);
        end
        @(posedge clk);
        #2;
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
        fails++;
        $display("FAIL vec%0d_valid: got %b exp 1", i, bus.out_valid);
      end
      checks++;
      if (bus.out_result !== te[i]) begin
        fails++;
        $display("FAIL vec%0d_result: got %h exp %h",
                 i, bus.out_result, te[i]);
      end
      checks++;
      if (bus.out_tag !== tag) begin
        fails++;
        $display("FAIL vec%0d_tag: got %h exp %h", i, bus.out_tag, tag);
      end
      @(posedge clk);
      #2;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL vec%0d_drain: got %b exp 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    // op t (tag t): t*3 * (t+100), unsigned, low word
    logic [31:0] te [5] = '{32'd303, 32'd612, 32'd927,
                            32'd1248, 32'd1575};
    logic        ev;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        drive_op(32'(3 * (c + 1)), 32'(c + 101), 1'b0, 1'b0, 1'b0,
                 5'(c + 1));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c < 5) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_in_ready%0d: got %b exp 1", c, bus.in_ready);
        end
      end
      @(posedge clk);
      #2;
      ev = (c >= 2 && c <= 6);
      checks++;
      if (bus.out_valid !== ev) begin
        fails++;
        $display("FAIL b2b_valid%0d: got %b exp %b", c, bus.out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (bus.out_tag !== 5'(c - 1) || bus.out_result !== te[c-2]) begin
          fails++;
          $display("FAIL b2b_out%0d: got tag %0d res %h exp tag %0d res %h",
                   c, bus.out_tag, bus.out_result, c - 1, te[c-2]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int   acc = 0;
    logic er;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive_op(32'(6 + acc), 32'h1000_0000, 1'b0, 1'b0, 1'b0, 5'(6 + acc));
      bus.in_valid = 1'b1;
      #1;
      er = (c < 3);
      checks++;
      if (bus.in_ready !== er) begin
        fails++;
        $display("FAIL stall_in_ready%0d: got %b exp %b",
                 c, bus.in_ready, er);
      end
      if (bus.in_ready) acc++;
      @(posedge clk);
      #2;
      if (c >= 2) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h6000_0000 ||
            bus.out_tag !== 5'd6) begin
          fails++;
          $display("FAIL stall_hold%0d: got v%b %h t%0d exp v1 60000000 t6",
                   c, bus.out_valid, bus.out_result, bus.out_tag);
        end
      end
    end
    checks++;
    if (acc !== 3) begin
      fails++;
      $display("FAIL stall_accepted: got %0d exp 3", acc);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'(6 + k) ||
          bus.out_result !== 32'(6 + k) << 28) begin
        fails++;
        $display("FAIL stall_drain%0d: got v%b t%0d %h exp t%0d %h",
                 k, bus.out_valid, bus.out_tag, bus.out_result,
                 6 + k, 32'(6 + k) << 28);
      end
      @(posedge clk);
      #2;
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_empty: got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    int w = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_op(32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 5'(10 + c));
      bus.in_valid = 1'b1;
      @(posedge clk);
      #2;
    end
    drive_op(32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 5'd13);
    flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_in_ready: got %b exp 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_quiet%0d: got %b exp 0", c, bus.out_valid);
      end
      @(posedge clk);
      #2;
    end
    drive_op(32'hFFFF_FFF9, 32'd6, 1'b1, 1'b1, 1'b0, 5'd14);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #1;
    while (!bus.out_valid && w < 10) begin
      @(posedge clk);
      #2;
      w++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFD6 ||
        bus.out_tag !== 5'd14) begin
      fails++;
      $display("FAIL flush_next: got v%b %h t%0d exp v1 ffffffd6 t14",
               bus.out_valid, bus.out_result, bus.out_tag);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_op(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 5'(20 + c));
      bus.in_valid = 1'b1;
      @(posedge clk);
      #2;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd25 ||
        bus.out_tag !== 5'd20) begin
      fails++;
      $display("FAIL rmid_pre: got v%b %h t%0d exp v1 19 t20",
               bus.out_valid, bus.out_result, bus.out_tag);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 ||
        bus.out_tag !== 5'h0) begin
      fails++;
      $display("FAIL rmid_async: got v%b %h t%0d exp v0 0 t0",
               bus.out_valid, bus.out_result, bus.out_tag);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    @(posedge clk);
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_after: got v%b rdy%b exp v0 rdy1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_random(input int n);
    logic [36:0] q[$];
    int sent = 0;
    int got  = 0;
    @(posedge clk);
    #1;
    fork
      begin
        logic [31:0] a, b;
        logic as, bs, hi, fire;
        logic [4:0] tag;
        int dc = 0;
        bus.in_valid = 1'b0;
        while (sent < n && dc < n * 8) begin
          if (!bus.in_valid && ($urandom % 4 != 0)) begin
            a   = pick();
            b   = pick();
            as  = 1'($urandom);
            bs  = as ? 1'($urandom) : 1'b0;
            hi  = 1'($urandom);
            tag = 5'(sent);
            drive_op(a, b, as, bs, hi, tag);
            bus.in_valid = 1'b1;
          end
          #1;
          fire = bus.in_valid && bus.in_ready;
          if (fire) begin
            q.push_back({tag, ref_word(a, b, as, bs, hi)});
            sent++;
          end
          @(posedge clk);
          #1;
          dc++;
          if (fire) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
      end
      begin
        logic [36:0] e;
        int cyc = 0;
        while (got < n && cyc < n * 8) begin
          bus.out_ready = ($urandom % 4 != 0);
          #1;
          if (bus.out_valid && bus.out_ready) begin
            e = (q.size() != 0) ? q.pop_front() : 37'h0;
            checks++;
            if ({bus.out_tag, bus.out_result} !== e) begin
              fails++;
              $display("FAIL rand_op%0d: got t%0d %h exp t%0d %h",
                       got, bus.out_tag, bus.out_result, e[36:32], e[31:0]);
            end
            got++;
          end
          @(posedge clk);
          #1;
          cyc++;
        end
        checks++;
        if (got !== n) begin
          fails++;
          $display("FAIL rand_count: got %0d results exp %0d", got, n);
        end
      end
    join
    #1;
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_hi     = 1'b0;
    bus.in_tag    = '0;
    bus.pp        = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_mul_vectors();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random(10000);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
